// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector.
// Holds the detection mode encoding, legal pattern length bounds and pattern helpers.
package seq_detect_pkg;

   typedef enum logic {
      MODE_NONOVERLAP = 1'b0,
      MODE_OVERLAP    = 1'b1
   } mode_e;

   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 32;

   // Widest pattern any instance can carry; narrower instances use the low bits.
   typedef logic [PAT_LEN_MAX-1:0] pat_t;

   function automatic bit pat_len_ok(input int len);
      return (len >= PAT_LEN_MIN) && (len <= PAT_LEN_MAX);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// It holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with a registered one-cycle match pulse.
// It supports overlapping and non-overlapping detection and keeps a saturating match count.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] RST_PAT = 4'b0100,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   input  logic               overlap,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   output logic               y,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy_fill
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
      $error("seq_detect_param: PAT_LEN out of range");
   end

   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               match_q, match_d;
   logic               y_q, y_d;

   logic [PAT_LEN-1:0] hist_shift;
   logic [FILL_W-1:0]  fill_shift;

   // A load restarts the history; otherwise an accepted bit shifts in and the
   // post-shift state is compared, with the fill gate blocking matches on a partial history.
   always_comb begin
      hist_d     = hist_q;
      fill_d     = fill_q;
      pat_d      = pat_q;
      match_d    = 1'b0;
      y_d        = match_q;
      hist_shift = {hist_q[PAT_LEN-2:0], in};
      fill_shift = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

      if (pat_load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         match_d = (fill_shift == FILL_FULL) && (hist_shift == pat_q);
         hist_d  = hist_shift;
         fill_d  = (match_d && (overlap == MODE_NONOVERLAP)) ? '0 : fill_shift;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= RST_PAT;
         match_q <= 1'b0;
         y_q     <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         match_q <= match_d;
         y_q     <= y_d;
      end
   end

   // Counting from match_q makes the count move on the same edge that y rises.
   sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match_q),
      .clr   (1'b0),
      .count (match_cnt)
   );

   assign y         = y_q;
   assign busy_fill = (fill_q < FILL_FULL);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_seq_detect_param;

   logic       clk;
   logic       reset;
   logic       in_bit;
   logic       in_valid;
   logic       overlap;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       y;
   logic [7:0] match_cnt;
   logic       busy_fill;
   logic       y2;
   logic [1:0] match_cnt2;
   logic       busy_fill2;

   int checks;
   int failures;

   seq_detect_param #(
      .PAT_LEN (4),
      .RST_PAT (4'b0100),
      .CNT_W   (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_bit),
      .in_valid  (in_valid),
      .overlap   (overlap),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .y         (y),
      .match_cnt (match_cnt),
      .busy_fill (busy_fill)
   );

   seq_detect_param #(
      .PAT_LEN (4),
      .RST_PAT (4'b0100),
      .CNT_W   (2)
   ) dut2 (
      .clk       (clk),
      .reset     (reset),
      .in        (in_bit),
      .in_valid  (in_valid),
      .overlap   (overlap),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .y         (y2),
      .match_cnt (match_cnt2),
      .busy_fill (busy_fill2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus helpers: each one spans exactly one rising edge and returns #1 after it.
   task automatic send_bit(input logic b);
      in_bit   = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic load_pat(input logic [3:0] p);
      pat_in   = p;
      pat_load = 1'b1;
      @(posedge clk);
      #1;
      pat_load = 1'b0;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      pat_load = 1'b0;
      in_bit   = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (y !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_y got=%b exp=0", y);
      end
      checks++;
      if (match_cnt !== 8'd0) begin
         failures++;
         $display("[TB] FAIL reset_cnt got=%0d exp=0", match_cnt);
      end
      checks++;
      if (busy_fill !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_busy got=%b exp=1", busy_fill);
      end
      checks++;
      if (match_cnt2 !== 2'd0) begin
         failures++;
         $display("[TB] FAIL reset_cnt2 got=%0d exp=0", match_cnt2);
      end
   endtask

   // trace[i] holds y sampled after edge i+1 of the stream.
   task automatic run_stream_0100(input logic ov, input logic [7:0] exp_trace,
                                  input logic [7:0] exp_cnt, input string name);
      logic [6:0] stream;
      logic [7:0] trace;
      stream  = 7'b0100100;
      trace   = '0;
      do_reset();
      overlap = ov;
      for (int i = 6; i >= 0; i--) begin
         send_bit(stream[i]);
         trace[6-i] = y;
      end
      idle_cycle();
      trace[7] = y;
      checks++;
      if (trace !== exp_trace) begin
         failures++;
         $display("[TB] FAIL %s_trace got=%b exp=%b", name, trace, exp_trace);
      end
      checks++;
      if (match_cnt !== exp_cnt) begin
         failures++;
         $display("[TB] FAIL %s_cnt got=%0d exp=%0d", name, match_cnt, exp_cnt);
      end
   endtask

   task automatic test_overlap();
      run_stream_0100(1'b1, 8'b1001_0000, 8'd2, "overlap");
   endtask

   task automatic test_nonoverlap();
      run_stream_0100(1'b0, 8'b0001_0000, 8'd1, "nonoverlap");
   endtask

   task automatic test_back_to_back();
      logic [9:0] trace;
      trace = '0;
      do_reset();
      overlap = 1'b1;
      load_pat(4'b1111);
      for (int i = 0; i < 6; i++) begin
         send_bit(1'b1);
         trace[i] = y;
      end
      idle_cycle();
      trace[6] = y;
      idle_cycle();
      trace[7] = y;
      checks++;
      if (match_cnt !== 8'd3) begin
         failures++;
         $display("[TB] FAIL b2b_cnt_gap got=%0d exp=3", match_cnt);
      end
      send_bit(1'b1);
      trace[8] = y;
      idle_cycle();
      trace[9] = y;
      checks++;
      if (trace !== 10'b10_0111_0000) begin
         failures++;
         $display("[TB] FAIL b2b_trace got=%b exp=%b", trace, 10'b10_0111_0000);
      end
      checks++;
      if (match_cnt !== 8'd4) begin
         failures++;
         $display("[TB] FAIL b2b_cnt_end got=%0d exp=4", match_cnt);
      end
   endtask

   task automatic test_zero_pattern();
      do_reset();
      overlap = 1'b1;
      load_pat(4'b0000);
      for (int i = 0; i < 3; i++) begin
         send_bit(1'b0);
         checks++;
         if (y !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_y_bit%0d got=%b exp=0", i, y);
         end
         checks++;
         if (busy_fill !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_busy_bit%0d got=%b exp=1", i, busy_fill);
         end
      end
      send_bit(1'b0);
      checks++;
      if (busy_fill !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_busy_full got=%b exp=0", busy_fill);
      end
      idle_cycle();
      checks++;
      if (y !== 1'b1) begin
         failures++;
         $display("[TB] FAIL zero_pulse got=%b exp=1", y);
      end
   endtask

   task automatic test_load_collision();
      do_reset();
      overlap = 1'b1;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      in_bit   = 1'b0;
      in_valid = 1'b1;
      load_pat(4'b0100);
      in_valid = 1'b0;
      idle_cycle();
      checks++;
      if (y !== 1'b0) begin
         failures++;
         $display("[TB] FAIL collide_y got=%b exp=0", y);
      end
      checks++;
      if (busy_fill !== 1'b1) begin
         failures++;
         $display("[TB] FAIL collide_busy got=%b exp=1", busy_fill);
      end
      // A match registered just before a load must still produce its pulse.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      load_pat(4'b0100);
      checks++;
      if (y !== 1'b1) begin
         failures++;
         $display("[TB] FAIL inflight_y got=%b exp=1", y);
      end
      checks++;
      if (match_cnt !== 8'd1) begin
         failures++;
         $display("[TB] FAIL inflight_cnt got=%0d exp=1", match_cnt);
      end
      checks++;
      if (busy_fill !== 1'b1) begin
         failures++;
         $display("[TB] FAIL inflight_busy got=%b exp=1", busy_fill);
      end
   endtask

   task automatic test_saturation_and_async_reset();
      do_reset();
      overlap = 1'b1;
      load_pat(4'b1111);
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      idle_cycle();
      checks++;
      if (match_cnt2 !== 2'd3) begin
         failures++;
         $display("[TB] FAIL sat_cnt2 got=%0d exp=3", match_cnt2);
      end
      checks++;
      if (match_cnt !== 8'd5) begin
         failures++;
         $display("[TB] FAIL sat_cnt8 got=%0d exp=5", match_cnt);
      end
      send_bit(1'b1);
      send_bit(1'b1);
      checks++;
      if (y !== 1'b1) begin
         failures++;
         $display("[TB] FAIL pre_reset_y got=%b exp=1", y);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (y !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset_y got=%b exp=0", y);
      end
      checks++;
      if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
         failures++;
         $display("[TB] FAIL async_reset_cnt got=%0d/%0d exp=0/0", match_cnt, match_cnt2);
      end
      checks++;
      if (busy_fill !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_reset_busy got=%b exp=1", busy_fill);
      end
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      // Fresh history with the reset pattern restored.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      idle_cycle();
      checks++;
      if (y !== 1'b1 || match_cnt !== 8'd1) begin
         failures++;
         $display("[TB] FAIL post_reset_match y=%b cnt=%0d exp y=1 cnt=1", y, match_cnt);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      in_bit   = 1'b0;
      in_valid = 1'b0;
      overlap  = 1'b1;
      pat_load = 1'b0;
      pat_in   = 4'b0000;
      #12;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_back_to_back();
      test_zero_pattern();
      test_load_collision();
      test_saturation_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
